// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: FIFO-buffered UART transmitter, LSB-first, parametrised width,
// baud divisor and stop-bit count. Define UART_TX_PARITY_EN to add a parity bit
// (and the in_parity_odd port) between the data bits and the stop bits.
module uart_tx_fifo #(
  parameter int unsigned DATA_W     = 6,
  parameter int unsigned CLK_DIV    = 16,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          in_clk,
  input  logic                          in_rst,
  input  logic                          in_start,
`ifdef UART_TX_PARITY_EN
  input  logic                          in_parity_odd,
`endif
  input  logic [DATA_W-1:0]             in_data,
  output logic                          out_tx,
  output logic                          out_busy,
  output logic                          out_done,
  output logic                          out_full,
  output logic [$clog2(FIFO_DEPTH):0]   out_level,
  output logic                          out_ovf
);

  localparam int unsigned PTR_W    = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W    = PTR_W + 1;
  localparam int unsigned BIT_W    = $clog2(DATA_W);
  localparam int unsigned STOP_LEN = STOP_BITS * CLK_DIV;
  // Counter is sized for the longest state (STOP spans all stop bits).
  localparam int unsigned CNT_W    = $clog2(STOP_LEN);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] STOP   = 3'd3;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] PARITY = 3'd4;
`endif

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [LVL_W-1:0]  level_q;
  logic [LVL_W-1:0]  level_d;
  logic              full_c;
  logic              empty_c;
  logic              push_c;
  logic              pop_c;

  logic [2:0]        state_q;
  logic [2:0]        state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;
  logic [BIT_W-1:0]  bit_q;
  logic [BIT_W-1:0]  bit_d;
  logic [DATA_W-1:0] shift_q;
  logic [DATA_W-1:0] shift_d;
  logic              tx_d;
  logic              done_d;
`ifdef UART_TX_PARITY_EN
  logic              par_q;
  logic              par_d;
`endif

  assign out_level = level_q;

  // FIFO occupancy; fullness is judged on the pre-edge level, so a push while full drops even if a pop happens
  always_comb begin
    full_c  = (level_q == LVL_W'(FIFO_DEPTH));
    empty_c = (level_q == '0);
    push_c  = in_start & ~full_c;
    level_d = level_q + LVL_W'(push_c) - LVL_W'(pop_c);
  end

  // FIFO pointers, level and status flags
  always_ff @(posedge in_clk or negedge in_rst) begin
    if (!in_rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level_q  <= '0;
      out_full <= 1'b0;
      out_ovf  <= 1'b0;
    end else begin
      if (push_c) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_c)  rd_ptr <= rd_ptr + PTR_W'(1);
      level_q  <= level_d;
      out_full <= (level_d == LVL_W'(FIFO_DEPTH));
      out_ovf  <= in_start & full_c;
    end
  end

  // FIFO storage; contents need no reset since the level gates every read
  always_ff @(posedge in_clk) begin
    if (push_c) mem[wr_ptr] <= in_data;
  end

  // Next-state logic; line level and done are computed from the next state so they register in step with it
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop_c   = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      IDLE: begin
        if (!empty_c) begin
          pop_c   = 1'b1;
          state_d = START;
          cnt_d   = '0;
        end
      end
      START: begin
        if (cnt_q == CNT_W'(CLK_DIV - 1)) begin
          state_d = DATA;
          cnt_d   = '0;
          bit_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DATA: begin
        if (cnt_q == CNT_W'(CLK_DIV - 1)) begin
          cnt_d = '0;
          if (bit_q == BIT_W'(DATA_W - 1)) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_d   = bit_q + BIT_W'(1);
            shift_d = shift_q >> 1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (cnt_q == CNT_W'(CLK_DIV - 1)) begin
          state_d = STOP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
`endif
      STOP: begin
        if (cnt_q == CNT_W'(STOP_LEN - 1)) begin
          cnt_d = '0;
          if (!empty_c) begin
            pop_c   = 1'b1;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    if (pop_c) begin
      shift_d = mem[rd_ptr];
`ifdef UART_TX_PARITY_EN
      par_d   = (^mem[rd_ptr]) ^ in_parity_odd;
`endif
    end

    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_d = par_d;
`endif
      default: tx_d = 1'b1;
    endcase
    done_d = (state_d == STOP) && (cnt_d == CNT_W'(STOP_LEN - 1));
  end

  // State register and registered line/status outputs; reset drives the line high immediately
  always_ff @(posedge in_clk or negedge in_rst) begin
    if (!in_rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
`ifdef UART_TX_PARITY_EN
      par_q    <= 1'b0;
`endif
      out_tx   <= 1'b1;
      out_done <= 1'b0;
      out_busy <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
`ifdef UART_TX_PARITY_EN
      par_q    <= par_d;
`endif
      out_tx   <= tx_d;
      out_done <= done_d;
      out_busy <= (state_d != IDLE) || (level_d != '0);
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: scoreboard bench for uart_tx_fifo. DUT a uses CLK_DIV=4,
// STOP_BITS=1; DUT b uses CLK_DIV=3, STOP_BITS=2. Both DATA_W=6, FIFO_DEPTH=4.
module tb_uart_tx_fifo;

  localparam int DW    = 6;
  localparam int CD_A  = 4;
  localparam int SB_A  = 1;
  localparam int CD_B  = 3;
  localparam int SB_B  = 2;
  localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
  localparam int PE = 1;
`else
  localparam int PE = 0;
`endif
  localparam int FRAME_A = (1 + PE + DW + SB_A) * CD_A;
  localparam int FRAME_B = (1 + PE + DW + SB_B) * CD_B;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       parity_odd;
  logic       start_a, start_b;
  logic [5:0] data_a, data_b;
  logic       tx_a, busy_a, done_a, full_a, ovf_a;
  logic       tx_b, busy_b, done_b, full_b, ovf_b;
  logic [2:0] level_a, level_b;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int n_done = 0;

  logic [8:0] sb_w[$];
  logic       sb_o[$];
  int         done_t[$];

  uart_tx_fifo #(.DATA_W(DW), .CLK_DIV(CD_A), .STOP_BITS(SB_A), .FIFO_DEPTH(DEPTH)) dut_a (
    .in_clk(clk), .in_rst(rst_n), .in_start(start_a),
`ifdef UART_TX_PARITY_EN
    .in_parity_odd(parity_odd),
`endif
    .in_data(data_a), .out_tx(tx_a), .out_busy(busy_a), .out_done(done_a),
    .out_full(full_a), .out_level(level_a), .out_ovf(ovf_a)
  );

  uart_tx_fifo #(.DATA_W(DW), .CLK_DIV(CD_B), .STOP_BITS(SB_B), .FIFO_DEPTH(DEPTH)) dut_b (
    .in_clk(clk), .in_rst(rst_n), .in_start(start_b),
`ifdef UART_TX_PARITY_EN
    .in_parity_odd(parity_odd),
`endif
    .in_data(data_b), .out_tx(tx_b), .out_busy(busy_b), .out_done(done_b),
    .out_full(full_b), .out_level(level_b), .out_ovf(ovf_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected line level at frame cycle p (p=0 is the first start-bit cycle)
  function automatic logic exp_bit(input logic [8:0] w, input logic odd, input int p, input int cd);
    int   slot;
    logic par;
    slot = p / cd;
    par  = odd;
    for (int i = 0; i < DW; i++) par = par ^ w[i];
    if (slot == 0) return 1'b0;
    if (slot <= DW) return w[slot-1];
    if (PE != 0 && slot == DW + 1) return par;
    return 1'b1;
  endfunction

  // Receiver for DUT a: pops the scoreboard at each start bit and checks every cycle of the frame
  logic       m_act = 1'b0;
  int         m_p = 0;
  logic [8:0] m_w = '0;
  logic       m_o = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      m_act = 1'b0;
    end else begin
      if (!m_act && tx_a === 1'b0) begin
        if (sb_w.size() == 0) begin
          chk("unexpected_frame", 32'(sb_w.size()), 32'd1);
          m_w = '0;
          m_o = 1'b0;
        end else begin
          m_w = sb_w.pop_front();
          m_o = sb_o.pop_front();
        end
        m_act = 1'b1;
        m_p   = 0;
      end
      if (m_act) begin
        chk($sformatf("tx_a_w%0h_p%0d", m_w, m_p), 32'(tx_a), 32'(exp_bit(m_w, m_o, m_p, CD_A)));
        chk($sformatf("done_a_p%0d", m_p), 32'(done_a), 32'(m_p == FRAME_A - 1));
        if (m_p == FRAME_A - 1) begin
          m_act = 1'b0;
          n_done++;
          done_t.push_back(cyc);
        end else begin
          m_p++;
        end
      end
    end
  end

  task automatic push_a(input logic [5:0] w, input logic acc);
    start_a = 1'b1;
    data_a  = w;
    if (acc) begin
      sb_w.push_back(9'(w));
      sb_o.push_back(parity_odd);
    end
    @(posedge clk); #1;
    start_a = 1'b0;
    data_a  = 6'($urandom);
  endtask

  task automatic wait_done(input int target, input int budget);
    int n;
    n = 0;
    while (n_done < target && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    chk("frame_timeout", 32'(n_done >= target), 32'd1);
  endtask

  logic [5:0] ow [6] = '{6'h2a, 6'h15, 6'h3c, 6'h03, 6'h27, 6'h18};
  int         exp_lvl [6] = '{1, 1, 2, 3, 4, 4};

  initial begin
    int k;
    int base;
    rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0;
    data_a = '0; data_b = '0; parity_odd = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx_a",    32'(tx_a),    32'd1);
    chk("rst_busy_a",  32'(busy_a),  32'd0);
    chk("rst_level_a", 32'(level_a), 32'd0);
    chk("rst_full_a",  32'(full_a),  32'd0);
    chk("rst_done_a",  32'(done_a),  32'd0);
    chk("rst_ovf_a",   32'(ovf_a),   32'd0);
    chk("rst_tx_b",    32'(tx_b),    32'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single frame: latency, done position, busy fall
    push_a(6'b101010, 1'b1);
    k = cyc;
    chk("push_level", 32'(level_a), 32'd1);
    chk("push_busy",  32'(busy_a),  32'd1);
    chk("push_tx",    32'(tx_a),    32'd1);
    @(posedge clk); #1;
    chk("start_tx",    32'(tx_a),    32'd0);
    chk("start_level", 32'(level_a), 32'd0);
    wait_done(1, FRAME_A + 10);
    chk("done_cycle", 32'(done_t.size() > 0 ? done_t[0] - k : -1), 32'(FRAME_A));
    chk("busy_fall",  32'(busy_a), 32'd0);
    chk("idle_tx",    32'(tx_a),   32'd1);

    // Back-to-back frames with no idle gap
    done_t.delete();
    base = n_done;
    push_a(6'b101010, 1'b1);
    push_a(6'b010101, 1'b1);
    wait_done(base + 2, 2 * FRAME_A + 10);
    chk("b2b_spacing", 32'(done_t.size() > 1 ? done_t[1] - done_t[0] : -1), 32'(FRAME_A));
    chk("b2b_busy_fall", 32'(busy_a), 32'd0);

    // Overflow: six pushes, the sixth is dropped
    base = n_done;
    for (int i = 0; i < 6; i++) begin
      push_a(ow[i], 1'(i < 5));
      chk($sformatf("ovf_level_%0d", i), 32'(level_a), 32'(exp_lvl[i]));
      chk($sformatf("ovf_full_%0d", i),  32'(full_a),  32'(i >= 4));
      chk($sformatf("ovf_pulse_%0d", i), 32'(ovf_a),   32'(i == 5));
    end
    @(posedge clk); #1;
    chk("ovf_pulse_end", 32'(ovf_a), 32'd0);
    wait_done(base + 5, 5 * FRAME_A + 20);
    repeat (FRAME_A + 4) @(posedge clk);
    #1;
    chk("ovf_frames",   32'(n_done - base), 32'd5);
    chk("ovf_sb_empty", 32'(sb_w.size()),   32'd0);
    chk("ovf_idle",     32'(busy_a),        32'd0);
    chk("ovf_level0",   32'(level_a),       32'd0);

    // DUT b: two stop bits, CLK_DIV=3
    start_b = 1'b1;
    data_b  = 6'b110100;
    @(posedge clk); #1;
    start_b = 1'b0;
    data_b  = 6'($urandom);
    for (int p = 0; p < FRAME_B; p++) begin
      @(posedge clk); #1;
      chk($sformatf("tx_b_p%0d", p),   32'(tx_b),   32'(exp_bit(9'h034, parity_odd, p, CD_B)));
      chk($sformatf("done_b_p%0d", p), 32'(done_b), 32'(p == FRAME_B - 1));
    end
    @(posedge clk); #1;
    chk("b_idle_tx",   32'(tx_b),   32'd1);
    chk("b_busy_fall", 32'(busy_b), 32'd0);

`ifdef UART_TX_PARITY_EN
    // Parity bit, even then odd
    base = n_done;
    parity_odd = 1'b0;
    push_a(6'b101010, 1'b1);
    wait_done(base + 1, FRAME_A + 10);
    parity_odd = 1'b1;
    push_a(6'b101010, 1'b1);
    wait_done(base + 2, FRAME_A + 10);
    parity_odd = 1'b0;
`endif

    // Reset mid-DATA with words still queued
    base = n_done;
    push_a(6'b000000, 1'b1);
    push_a(6'h15, 1'b1);
    push_a(6'h2a, 1'b1);
    repeat (5) @(posedge clk);
    #1;
    chk("mid_data_tx",    32'(tx_a),    32'd0);
    chk("mid_data_level", 32'(level_a), 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_tx",    32'(tx_a),    32'd1);
    chk("arst_level", 32'(level_a), 32'd0);
    chk("arst_busy",  32'(busy_a),  32'd0);
    chk("arst_full",  32'(full_a),  32'd0);
    sb_w.delete();
    sb_o.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (FRAME_A) @(posedge clk);
    #1;
    chk("post_rst_no_frames", 32'(n_done - base), 32'd0);
    chk("post_rst_tx",        32'(tx_a),          32'd1);
    chk("post_rst_busy",      32'(busy_a),        32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
